// File: rtl/srec_word_packer.sv
// srec_word_packer: packs parser byte writes into little-endian 32-bit words with byte enables and queues them for a word-wide memory port; ports clock/reset, parser byte stream in, flush pulse in, mem_* valid/ready word port out, sticky overflow and busy status out.
module srec_word_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] write_address,
  input  logic [7:0]  write_byte,
  input  logic        write_enable,
  input  logic        flush,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        overflow,
  output logic        busy
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  logic [29:0] acc_addr_q, acc_addr_d;
  logic [31:0] acc_data_q, acc_data_d;
  logic [3:0]  acc_be_q, acc_be_d;
  logic        flush_pending_q, flush_pending_d;
  logic        overflow_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic [29:0] fifo_addr [FIFO_DEPTH];
  logic [31:0] fifo_data [FIFO_DEPTH];
  logic [3:0]  fifo_be   [FIFO_DEPTH];
  logic [1:0]  lane;
  logic [3:0]  new_be, merge_be;
  logic [31:0] new_data, merge_data;
  logic        push, pop, accept;
  logic [29:0] push_addr;
  logic [31:0] push_data;
  logic [3:0]  push_be;
  assign lane     = write_address[1:0];
  assign new_be   = 4'b0001 << lane;
  assign new_data = {24'b0, write_byte} << {lane, 3'b000};
  assign merge_be = acc_be_q | new_be;
  always_comb begin
    acc_addr_d      = acc_addr_q;
    acc_data_d      = acc_data_q;
    acc_be_d        = acc_be_q;
    flush_pending_d = flush_pending_q | flush;
    push            = 1'b0;
    push_addr       = acc_addr_q;
    push_data       = acc_data_q;
    push_be         = acc_be_q;
    merge_data      = acc_data_q;
    merge_data[{lane, 3'b000} +: 8] = write_byte;
    if (write_enable) begin
      if (acc_be_q == 4'h0 || write_address[31:2] != acc_addr_q) begin
        push       = acc_be_q != 4'h0;
        acc_addr_d = write_address[31:2];
        acc_data_d = new_data;
        acc_be_d   = new_be;
      end else if (merge_be == 4'hF) begin
        push      = 1'b1;
        push_data = merge_data;
        push_be   = merge_be;
        acc_be_d  = 4'h0;
      end else begin
        acc_data_d = merge_data;
        acc_be_d   = merge_be;
      end
    end else if (flush_pending_d) begin
      push            = acc_be_q != 4'h0;
      acc_be_d        = 4'h0;
      flush_pending_d = 1'b0;
    end
  end
  assign pop    = (count_q != '0) && mem_ready;
  assign accept = push && ((count_q != CW'(FIFO_DEPTH)) || pop);
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_addr_q      <= '0;
      acc_data_q      <= '0;
      acc_be_q        <= '0;
      flush_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      wr_q            <= '0;
      rd_q            <= '0;
      count_q         <= '0;
    end else begin
      acc_addr_q      <= acc_addr_d;
      acc_data_q      <= acc_data_d;
      acc_be_q        <= acc_be_d;
      flush_pending_q <= flush_pending_d;
      overflow_q      <= overflow_q | (push && !accept);
      wr_q            <= wr_q + PW'(accept);
      rd_q            <= rd_q + PW'(pop);
      count_q         <= count_q + CW'(accept) - CW'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (accept) begin
      fifo_addr[wr_q] <= push_addr;
      fifo_data[wr_q] <= push_data;
      fifo_be[wr_q]   <= push_be;
    end
  end
  // Head fields are gated so an empty FIFO never exposes stale or uninitialised entries.
  assign mem_valid       = count_q != '0;
  assign mem_address     = mem_valid ? {fifo_addr[rd_q], 2'b00} : 32'h0;
  assign mem_data        = mem_valid ? fifo_data[rd_q] : 32'h0;
  assign mem_byte_enable = mem_valid ? fifo_be[rd_q] : 4'h0;
  assign overflow        = overflow_q;
  assign busy            = (acc_be_q != 4'h0) || (count_q != '0) || flush_pending_q;
endmodule

// File: tb/tb_srec_word_packer.sv
// tb_srec_word_packer: directed scoreboard bench for srec_word_packer.
module tb_srec_word_packer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] write_address = '0;
  logic [7:0]  write_byte = '0;
  logic        write_enable = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        overflow;
  logic        busy;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } word_t;
  word_t exp_q[$];
  int checks = 0;
  int failures = 0;
  srec_word_packer #(.FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .write_address(write_address), .write_byte(write_byte),
    .write_enable(write_enable), .flush(flush), .mem_address(mem_address), .mem_data(mem_data),
    .mem_byte_enable(mem_byte_enable), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .overflow(overflow), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic wb(input logic [31:0] a, input logic [7:0] d, input logic f);
    write_address = a;
    write_byte = d;
    write_enable = 1'b1;
    flush = f;
    tick();
    write_enable = 1'b0;
    flush = 1'b0;
  endtask
  task automatic wword(input logic [31:0] a, input logic [31:0] d);
    for (int j = 0; j < 4; j++) wb(a + 32'(j), d[8*j +: 8], 1'b0);
  endtask
  task automatic expect_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    word_t w;
    w.addr = a;
    w.data = d;
    w.be = be;
    exp_q.push_back(w);
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask
  always @(negedge clock) begin
    if (!reset && mem_valid && mem_ready) begin
      if (exp_q.size() == 0) chk("spurious_xfer", 64'(mem_valid), 64'd0);
      else begin
        word_t e;
        logic [31:0] m;
        e = exp_q.pop_front();
        m = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
        chk("xfer_addr", 64'(mem_address), 64'(e.addr));
        chk("xfer_be", 64'(mem_byte_enable), 64'(e.be));
        chk("xfer_data", 64'(mem_data & m), 64'(e.data & m));
      end
    end
  end
  initial begin
    tick();
    tick();
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_addr", 64'(mem_address), 64'd0);
    chk("rst_data", 64'(mem_data), 64'd0);
    chk("rst_be", 64'(mem_byte_enable), 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);
    mem_ready = 1'b1;
    wb(32'h100, 8'h11, 1'b0);
    tick();
    wb(32'h101, 8'h22, 1'b0);
    tick();
    wb(32'h102, 8'h33, 1'b0);
    tick();
    chk("t1_not_yet", 64'(mem_valid), 64'd0);
    expect_w(32'h100, 32'h44332211, 4'hF);
    wb(32'h103, 8'h44, 1'b0);
    chk("t1_latency", 64'(mem_valid), 64'd1);
    chk("t1_head", 64'(mem_address), 64'h100);
    drain("t1_drain");
    chk("t1_busy", 64'(busy), 64'd0);
    wb(32'h202, 8'hAA, 1'b0);
    wb(32'h203, 8'hBB, 1'b0);
    expect_w(32'h200, 32'hBBAA0000, 4'hC);
    expect_w(32'h204, 32'h000000CC, 4'h1);
    wb(32'h204, 8'hCC, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain("t2_drain");
    chk("t2_busy", 64'(busy), 64'd0);
    expect_w(32'h300, 32'h00000055, 4'h1);
    wb(32'h300, 8'h55, 1'b1);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_no_push", 64'(mem_valid), 64'd0);
    tick();
    chk("t3_pushed", 64'(mem_valid), 64'd1);
    drain("t3_drain");
    chk("t3_busy_clr", 64'(busy), 64'd0);
    wb(32'h400, 8'h77, 1'b0);
    wb(32'h400, 8'h88, 1'b0);
    expect_w(32'h400, 32'h00000088, 4'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain("ovw_drain");
    expect_w(32'hFFFFFFFC, 32'h04030201, 4'hF);
    wword(32'hFFFFFFFC, 32'h04030201);
    drain("top_drain");
    mem_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) expect_w(32'(4 * k), 32'h01020304 + 32'(k) * 32'h10101010, 4'hF);
      wword(32'(4 * k), 32'h01020304 + 32'(k) * 32'h10101010);
      if (k == 3) chk("bp_ovf_before", 64'(overflow), 64'd0);
      if (k == 4) chk("bp_ovf_after", 64'(overflow), 64'd1);
    end
    tick();
    tick();
    chk("bp_valid", 64'(mem_valid), 64'd1);
    chk("bp_head_stable", 64'(mem_address), 64'h0);
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("bp_one_left", 64'(mem_valid), 64'd1);
    tick();
    chk("bp_empty", 64'(exp_q.size()), 64'd0);
    chk("bp_valid_clr", 64'(mem_valid), 64'd0);
    chk("bp_ovf_sticky", 64'(overflow), 64'd1);
    mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("bp_ovf_reset", 64'(overflow), 64'd0);
    for (int k = 0; k < 4; k++) begin
      expect_w(32'h500 + 32'(4 * k), 32'hA0B0C0D0 + 32'(k), 4'hF);
      wword(32'h500 + 32'(4 * k), 32'hA0B0C0D0 + 32'(k));
    end
    expect_w(32'h510, 32'h5A5B5C5D, 4'hF);
    wb(32'h510, 8'h5D, 1'b0);
    wb(32'h511, 8'h5C, 1'b0);
    wb(32'h512, 8'h5B, 1'b0);
    mem_ready = 1'b1;
    wb(32'h513, 8'h5A, 1'b0);
    mem_ready = 1'b0;
    chk("pp_ovf", 64'(overflow), 64'd0);
    chk("pp_head", 64'(mem_address), 64'h504);
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("pp_count4", 64'(mem_valid), 64'd1);
    tick();
    chk("pp_empty", 64'(exp_q.size()), 64'd0);
    chk("pp_valid_clr", 64'(mem_valid), 64'd0);
    mem_ready = 1'b0;
    wword(32'h600, 32'h11223344);
    wword(32'h604, 32'h55667788);
    wb(32'h608, 8'h99, 1'b0);
    chk("rm_busy", 64'(busy), 64'd1);
    chk("rm_valid", 64'(mem_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_valid_clr", 64'(mem_valid), 64'd0);
    chk("rm_busy_clr", 64'(busy), 64'd0);
    chk("rm_ovf", 64'(overflow), 64'd0);
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("rm_no_stale", 64'(mem_valid), 64'd0);
    expect_w(32'h700, 32'h000000EE, 4'h1);
    wb(32'h700, 8'hEE, 1'b1);
    tick();
    drain("rm_fresh_drain");
    chk("rm_busy_end", 64'(busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
